// File: rtl/fb_striped_write_scheduler_pkg.sv
// Shared types and constants for the striped framebuffer write scheduler.
package fb_striped_write_scheduler_pkg;

  // Per-stripe write port state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } stripe_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/fb_striped_write_scheduler_if.sv
// Bundles the pixel write request stream, display hold/status and the
// per-stripe AXI write channels. "master" is the environment side,
// "slave" is the scheduler.
interface fb_striped_write_scheduler_if #(
  parameter int NUM_S          = 2,
  parameter int PIXEL_BITS     = 12,
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16
);
  // request stream and status
  logic                                         in_valid;
  logic                                         in_ready;
  logic [AXI_ADDR_WIDTH-1:0]                    in_addr;
  logic [PIXEL_BITS-1:0]                        in_color;
  logic                                         hold;
  logic                                         busy;
  logic                                         err;
  // per-stripe AXI write channels
  logic [NUM_S-1:0][AXI_ADDR_WIDTH-1:0]         fb_axi_awaddr;
  logic [NUM_S-1:0]                             fb_axi_awvalid;
  logic [NUM_S-1:0]                             fb_axi_awready;
  logic [NUM_S-1:0][AXI_DATA_WIDTH-1:0]         fb_axi_wdata;
  logic [NUM_S-1:0][AXI_DATA_WIDTH/8-1:0]       fb_axi_wstrb;
  logic [NUM_S-1:0]                             fb_axi_wvalid;
  logic [NUM_S-1:0]                             fb_axi_wready;
  logic [NUM_S-1:0][1:0]                        fb_axi_bresp;
  logic [NUM_S-1:0]                             fb_axi_bvalid;
  logic [NUM_S-1:0]                             fb_axi_bready;

  modport master (
    output in_valid, in_addr, in_color, hold,
    input  in_ready, busy, err,
    input  fb_axi_awaddr, fb_axi_awvalid,
    output fb_axi_awready,
    input  fb_axi_wdata, fb_axi_wstrb, fb_axi_wvalid,
    output fb_axi_wready,
    output fb_axi_bresp, fb_axi_bvalid,
    input  fb_axi_bready
  );

  modport slave (
    input  in_valid, in_addr, in_color, hold,
    output in_ready, busy, err,
    output fb_axi_awaddr, fb_axi_awvalid,
    input  fb_axi_awready,
    output fb_axi_wdata, fb_axi_wstrb, fb_axi_wvalid,
    input  fb_axi_wready,
    input  fb_axi_bresp, fb_axi_bvalid,
    output fb_axi_bready
  );

endinterface

// File: rtl/fb_striped_write_scheduler_axi_write_port.sv
// Single-stripe AXI write port: captures one pixel write, issues AW and W
// independently, then waits for the B response before going idle again.
module fb_striped_write_scheduler_axi_write_port
  import fb_striped_write_scheduler_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_accept,
  input  logic [AXI_ADDR_WIDTH-1:0]     i_waddr,
  input  logic [AXI_DATA_WIDTH-1:0]     i_wdata,
  input  logic                          i_awready,
  input  logic                          i_wready,
  input  logic [1:0]                    i_bresp,
  input  logic                          i_bvalid,
  output logic [AXI_ADDR_WIDTH-1:0]     o_awaddr,
  output logic                          o_awvalid,
  output logic [AXI_DATA_WIDTH-1:0]     o_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   o_wstrb,
  output logic                          o_wvalid,
  output logic                          o_bready,
  output logic                          o_idle,
  output logic                          o_bad_resp
);

  stripe_state_t               r_state;
  logic [AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [AXI_DATA_WIDTH-1:0]   r_wdata;
  logic                        r_awvalid;
  logic                        r_wvalid;
  logic                        r_bready;

  // A channel counts as done once its valid is low or is being taken now
  logic w_aw_done;
  logic w_w_done;
  assign w_aw_done = !r_awvalid || i_awready;
  assign w_w_done  = !r_wvalid  || i_wready;

  // Stripe FSM with registered AXI channel outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_accept) begin
            r_awaddr  <= i_waddr;
            r_wdata   <= i_wdata;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          // address/data stay put; only the valids drop after their handshakes
          if (r_awvalid && i_awready) r_awvalid <= 1'b0;
          if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= RESP;
          end
        end
        RESP: begin
          if (i_bvalid) begin
            r_bready <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_awaddr   = r_awaddr;
  assign o_awvalid  = r_awvalid;
  assign o_wdata    = r_wdata;
  assign o_wvalid   = r_wvalid;
  assign o_wstrb    = {(AXI_DATA_WIDTH/8){r_wvalid}};
  assign o_bready   = r_bready;
  assign o_idle     = (r_state == IDLE);
  assign o_bad_resp = r_bready && i_bvalid && (i_bresp != AXI_RESP_OKAY);

endmodule

// File: rtl/fb_striped_write_scheduler.sv
// Striped framebuffer write scheduler: routes each pixel write to the SRAM
// stripe selected by the low address bits and tracks busy/error status.
module fb_striped_write_scheduler
  import fb_striped_write_scheduler_pkg::*;
#(
  parameter int NUM_S          = 2,
  parameter int PIXEL_BITS     = 12,
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16
) (
  input  logic                        axi_clk,
  input  logic                        axi_resetn,
  fb_striped_write_scheduler_if.slave bus
);

  localparam int STRIPE_BITS = $clog2(NUM_S);

  logic [STRIPE_BITS-1:0]     w_sel;
  logic [AXI_ADDR_WIDTH-1:0]  w_waddr;
  logic [AXI_DATA_WIDTH-1:0]  w_wdata;
  logic [NUM_S-1:0]           w_idle;
  logic [NUM_S-1:0]           w_accept;
  logic [NUM_S-1:0]           w_bad_resp;
  logic                       r_err;

  // stripe = addr % NUM_S, word address = addr / NUM_S
  assign w_sel   = bus.in_addr[STRIPE_BITS-1:0];
  assign w_waddr = bus.in_addr >> STRIPE_BITS;
  assign w_wdata = AXI_DATA_WIDTH'(bus.in_color);

  // Ready only toward an idle stripe, never while the display holds or in reset
  assign bus.in_ready = axi_resetn && !bus.hold && w_idle[w_sel];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_S; gi++) begin : g_stripe
      assign w_accept[gi] = bus.in_valid && bus.in_ready &&
                            (w_sel == STRIPE_BITS'(gi));

      fb_striped_write_scheduler_axi_write_port #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
      ) u_port (
        .clk        (axi_clk),
        .rst_n      (axi_resetn),
        .i_accept   (w_accept[gi]),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_awready  (bus.fb_axi_awready[gi]),
        .i_wready   (bus.fb_axi_wready[gi]),
        .i_bresp    (bus.fb_axi_bresp[gi]),
        .i_bvalid   (bus.fb_axi_bvalid[gi]),
        .o_awaddr   (bus.fb_axi_awaddr[gi]),
        .o_awvalid  (bus.fb_axi_awvalid[gi]),
        .o_wdata    (bus.fb_axi_wdata[gi]),
        .o_wstrb    (bus.fb_axi_wstrb[gi]),
        .o_wvalid   (bus.fb_axi_wvalid[gi]),
        .o_bready   (bus.fb_axi_bready[gi]),
        .o_idle     (w_idle[gi]),
        .o_bad_resp (w_bad_resp[gi])
      );
    end
  endgenerate

  // Sticky error: any non-OKAY write response on any stripe
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) r_err <= 1'b0;
    else if (|w_bad_resp) r_err <= 1'b1;
  end

  assign bus.err  = r_err;
  assign bus.busy = |(~w_idle);

endmodule

// File: tb/tb_fb_striped_write_scheduler.sv
// Randomised bench for the striped write scheduler with a transaction-level
// model of each stripe and a stub AXI slave.
module tb_fb_striped_write_scheduler;

  localparam int NS = 2;
  localparam int PB = 12;
  localparam int AW = 20;
  localparam int DW = 16;

  logic axi_clk;
  logic axi_resetn;

  fb_striped_write_scheduler_if #(.NUM_S(NS), .PIXEL_BITS(PB),
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

  fb_striped_write_scheduler #(.NUM_S(NS), .PIXEL_BITS(PB),
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .axi_clk    (axi_clk),
    .axi_resetn (axi_resetn),
    .bus        (bus)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  int n_vec = 0;
  int n_err = 0;

  // model: a stripe is active from accept until its B handshake
  bit          m_act [NS];
  bit          m_aw  [NS];
  bit          m_w   [NS];
  logic [AW-1:0] m_addr [NS];
  logic [DW-1:0] m_data [NS];
  bit          m_err;
  // stub slave B channel
  bit          s_bv   [NS];
  logic [1:0]  s_resp [NS];
  int          bv_pct  = 100;
  int          bad_pct = 0;
  bit          last_acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < NS; s++) begin
      m_act[s] = 0; m_aw[s] = 0; m_w[s] = 0;
      s_bv[s] = 0; s_resp[s] = 2'b00;
      bus.fb_axi_bvalid[s] = 1'b0;
      bus.fb_axi_bresp[s]  = 2'b00;
    end
    m_err = 0;
  endtask

  // One clock: called at negedge with inputs set; checks, advances model, returns at negedge
  task automatic tick();
    bit exp_rdy;
    int sel;
    bit acc;
    bit aw_hs [NS];
    bit w_hs  [NS];
    bit b_hs  [NS];
    bit want_b;
    for (int s = 0; s < NS; s++) begin
      want_b = m_act[s] && !m_aw[s] && !m_w[s];
      if (axi_resetn && !s_bv[s] && want_b && ($urandom_range(99) < bv_pct)) begin
        s_bv[s]   = 1;
        s_resp[s] = ($urandom_range(99) < bad_pct) ? 2'($urandom_range(3, 1)) : 2'b00;
      end
      bus.fb_axi_bvalid[s] = s_bv[s];
      bus.fb_axi_bresp[s]  = s_resp[s];
    end
    #1;
    sel = int'(bus.in_addr % NS);
    exp_rdy = axi_resetn && !bus.hold && !m_act[sel];
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("busy", bus.busy, (m_act[0] || m_act[1]));
    chk("err", bus.err, m_err);
    for (int s = 0; s < NS; s++) begin
      want_b = m_act[s] && !m_aw[s] && !m_w[s];
      chk($sformatf("awvalid%0d", s), bus.fb_axi_awvalid[s], m_aw[s]);
      chk($sformatf("wvalid%0d", s), bus.fb_axi_wvalid[s], m_w[s]);
      chk($sformatf("bready%0d", s), bus.fb_axi_bready[s], want_b);
      chk($sformatf("wstrb%0d", s), bus.fb_axi_wstrb[s], m_w[s] ? 2'b11 : 2'b00);
      if (m_aw[s]) chk($sformatf("awaddr%0d", s), bus.fb_axi_awaddr[s], m_addr[s]);
      if (m_w[s])  chk($sformatf("wdata%0d", s), bus.fb_axi_wdata[s], m_data[s]);
      aw_hs[s] = m_aw[s] && bus.fb_axi_awready[s];
      w_hs[s]  = m_w[s] && bus.fb_axi_wready[s];
      b_hs[s]  = want_b && s_bv[s];
    end
    acc = bus.in_valid && exp_rdy;
    @(posedge axi_clk);
    if (axi_resetn) begin
      for (int s = 0; s < NS; s++) begin
        if (b_hs[s]) begin
          if (s_resp[s] != 2'b00) m_err = 1;
          m_act[s] = 0; s_bv[s] = 0; s_resp[s] = 2'b00;
        end
        if (aw_hs[s]) m_aw[s] = 0;
        if (w_hs[s])  m_w[s]  = 0;
      end
      if (acc) begin
        m_act[sel] = 1; m_aw[sel] = 1; m_w[sel] = 1;
        m_addr[sel] = bus.in_addr / NS;
        m_data[sel] = DW'(bus.in_color);
      end
    end
    last_acc = acc;
    @(negedge axi_clk);
  endtask

  task automatic set_slave(input bit awr, input bit wr);
    for (int s = 0; s < NS; s++) begin
      bus.fb_axi_awready[s] = awr;
      bus.fb_axi_wready[s]  = wr;
    end
  endtask

  // Assert reset at a negedge (possibly mid-transaction), check outputs, release
  task automatic do_reset();
    axi_resetn = 1'b0;
    model_clear();
    bus.in_valid = 1'b1;
    bus.hold = 1'b0;
    #1;
    chk("rst_awvalid", bus.fb_axi_awvalid, 2'b00);
    chk("rst_wvalid", bus.fb_axi_wvalid, 2'b00);
    chk("rst_bready", bus.fb_axi_bready, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_awaddr", bus.fb_axi_awaddr, 40'h0);
    chk("rst_wdata", bus.fb_axi_wdata, 32'h0);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge axi_clk);
    axi_resetn = 1'b1;
  endtask

  // Let outstanding writes finish with a bounded cycle budget
  task automatic drain();
    int n;
    bus.in_valid = 1'b0;
    set_slave(1, 1);
    bv_pct = 100;
    n = 0;
    while ((m_act[0] || m_act[1]) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_timeout", (m_act[0] || m_act[1]), 1'b0);
    chk("drain_busy", bus.busy, 1'b0);
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [PB-1:0] c);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_color = c;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin : main
    int waits;
    axi_resetn = 1'b0;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_color = '0; bus.hold = 1'b0;
    set_slave(0, 0);
    model_clear();
    @(negedge axi_clk);
    do_reset();

    // literal pin: addr 5 -> stripe 1, word 2, data zero-extended
    set_slave(0, 0);
    send(20'd5, 12'hABC);
    chk("lit_acc5", last_acc, 1'b1);
    chk("lit_awaddr1", bus.fb_axi_awaddr[1], 20'd2);
    chk("lit_wdata1", bus.fb_axi_wdata[1], 16'h0ABC);
    chk("lit_awvalid", bus.fb_axi_awvalid, 2'b10);
    // stripe 1 busy: addr 7 refused, addr 4 (stripe 0) accepted back-to-back
    send(20'd7, 12'h111);
    chk("lit_rej7", last_acc, 1'b0);
    send(20'd4, 12'h004);
    chk("lit_acc4", last_acc, 1'b1);
    chk("lit_both_addr", bus.fb_axi_awvalid & bus.fb_axi_wvalid, 2'b11);
    chk("lit_awaddr0", bus.fb_axi_awaddr[0], 20'd2);
    drain();

    // same stripe: addr 8 waits two cycles behind addr 6
    set_slave(1, 1);
    send(20'd6, 12'h006);
    bus.in_valid = 1'b1; bus.in_addr = 20'd8; bus.in_color = 12'h008;
    waits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_acc) break;
      waits++;
    end
    chk("lit_wait8", waits, 2);
    drain();

    // hold blocks accept, release lets it through
    set_slave(0, 0);
    bus.hold = 1'b1; bus.in_valid = 1'b1; bus.in_addr = 20'd3; bus.in_color = 12'h5A5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_hold_rej", last_acc, 1'b0);
      chk("lit_hold_noaw", bus.fb_axi_awvalid, 2'b00);
    end
    bus.hold = 1'b0;
    tick();
    chk("lit_hold_acc", last_acc, 1'b1);
    chk("lit_awaddr3", bus.fb_axi_awaddr[1], 20'd1);
    bus.in_valid = 1'b0;
    // slow W with stable data, error response
    bus.fb_axi_awready[1] = 1'b1;
    tick();
    bus.fb_axi_awready[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_wstable", bus.fb_axi_wdata[1], 16'h05A5);
    end
    bad_pct = 100;
    drain();
    bad_pct = 0;
    chk("lit_err_set", bus.err, 1'b1);
    send(20'd10, 12'h00A);
    drain();
    chk("lit_err_sticky", bus.err, 1'b1);

    // reset while stripe 1 is in ADDR, then a clean write to addr 1
    set_slave(0, 0);
    send(20'd1, 12'h321);
    do_reset();
    send(20'd1, 12'h0F1);
    chk("lit_post_rst_acc", last_acc, 1'b1);
    drain();
    chk("lit_post_rst_err", bus.err, 1'b0);

    // random traffic
    bv_pct = 50;
    bad_pct = 5;
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid = ($urandom_range(99) < 70);
      bus.in_addr  = AW'($urandom);
      bus.in_color = PB'($urandom);
      bus.hold     = ($urandom_range(99) < 20);
      for (int s = 0; s < NS; s++) begin
        bus.fb_axi_awready[s] = ($urandom_range(99) < 60);
        bus.fb_axi_wready[s]  = ($urandom_range(99) < 60);
      end
      if ($urandom_range(599) == 0) do_reset();
      else tick();
    end
    bad_pct = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
